// File: rtl/or_nor_arbiter_if.sv
// Requester/consumer bus of the shared OR/NOR unit.
// The master side is the requester and consumer environment; the slave side is the arbiter.
interface or_nor_arbiter_if #(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = 2,
   parameter int CW  = 8
);
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_x;
   logic [N*W-1:0] req_y;
   logic [N-1:0]   req_e;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_w;
   logic [IDW-1:0] res_id;
   logic [CW-1:0]  op_cnt;

   modport master (
      output req_valid, req_x, req_y, req_e, res_ready,
      input  req_ready, res_valid, res_w, res_id, op_cnt
   );

   modport slave (
      input  req_valid, req_x, req_y, req_e, res_ready,
      output req_ready, res_valid, res_w, res_id, op_cnt
   );
endinterface

// File: rtl/or_nor_arbiter.sv
// Round-robin shared bitwise OR/NOR unit with a single-entry tagged result register.
// A full register that drains in the same cycle accepts a new operation, so the
// block sustains one operation per cycle when the consumer never stalls.
module or_nor_arbiter #(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = 2,
   parameter int CW  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   or_nor_arbiter_if.slave      bus
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t         state_r;
   logic [W-1:0]   res_w_r;
   logic [IDW-1:0] res_id_r;
   logic [IDW-1:0] ptr_r;
   logic [CW-1:0]  op_cnt_r;

   logic           found_s;
   logic [IDW-1:0] grant_s;
   logic           can_acc_s;
   logic           accept_s;
   logic [W-1:0]   sel_x_s;
   logic [W-1:0]   sel_y_s;
   logic           sel_e_s;
   logic [N-1:0]   req_ready_s;

   // The shared unit: OR, or NOR when the mode bit is set.
   function automatic logic [W-1:0] or_nor(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         e);
      logic [W-1:0] v;
      v = x | y;
      return e ? ~v : v;
   endfunction

   // Round-robin scan: first valid index at or above ptr, else first valid below ptr.
   always_comb begin
      found_s = 1'b0;
      grant_s = {IDW{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (!found_s && bus.req_valid[i] && (IDW'(i) >= ptr_r)) begin
            found_s = 1'b1;
            grant_s = IDW'(i);
         end else begin
            found_s = found_s;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found_s && bus.req_valid[i] && (IDW'(i) < ptr_r)) begin
            found_s = 1'b1;
            grant_s = IDW'(i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Accept window and the one-hot ready; ready is held low while reset is asserted.
   always_comb begin
      can_acc_s   = (state_r == EMPTY) || bus.res_ready;
      accept_s    = found_s && can_acc_s && rst_n;
      req_ready_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (accept_s && (grant_s == IDW'(i))) begin
            req_ready_s[i] = 1'b1;
         end else begin
            req_ready_s[i] = 1'b0;
         end
      end
   end

   // Operand mux for the granted requester (constant part-selects only).
   always_comb begin
      sel_x_s = {W{1'b0}};
      sel_y_s = {W{1'b0}};
      sel_e_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant_s == IDW'(i)) begin
            sel_x_s = bus.req_x[i*W +: W];
            sel_y_s = bus.req_y[i*W +: W];
            sel_e_s = bus.req_e[i];
         end else begin
            sel_e_s = sel_e_s;
         end
      end
   end

   // Result register FSM: load on accept, drop to EMPTY on a drain without accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= EMPTY;
         res_w_r  <= {W{1'b0}};
         res_id_r <= {IDW{1'b0}};
         ptr_r    <= {IDW{1'b0}};
         op_cnt_r <= {CW{1'b0}};
      end else begin
         if (accept_s) begin
            res_w_r  <= or_nor(sel_x_s, sel_y_s, sel_e_s);
            res_id_r <= grant_s;
            ptr_r    <= (grant_s == IDW'(N-1)) ? {IDW{1'b0}} : grant_s + IDW'(1'b1);
            op_cnt_r <= op_cnt_r + CW'(1'b1);
         end else begin
            ptr_r    <= ptr_r;
         end
         case (state_r)
            EMPTY: begin
               if (accept_s) state_r <= FULL;
               else          state_r <= EMPTY;
            end
            FULL: begin
               if (accept_s)           state_r <= FULL;
               else if (bus.res_ready) state_r <= EMPTY;
               else                    state_r <= FULL;
            end
            default: state_r <= EMPTY;
         endcase
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.res_valid = (state_r == FULL);
   assign bus.res_w     = res_w_r;
   assign bus.res_id    = res_id_r;
   assign bus.op_cnt    = op_cnt_r;

endmodule
